// File: rtl/serial_subtractor_eight_bits.sv
// serial_subtractor_eight_bits
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first,
// through a single full-subtractor cell fed from shift registers.
// Handshake: start accepted in IDLE or DONE; busy while shifting; done pulses
// for one cycle when D/Bout/V update. Results hold until the next completion.
// Optional macro SERIAL_SUB_ADD_MODE_EN adds a 'mode' input (1 = add, with
// Bout carrying the carry-out). The macro-undefined build is subtract only.
module serial_subtractor_eight_bits #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
`ifdef SERIAL_SUB_ADD_MODE_EN
   input  logic             mode,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic             V
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bw_q, bw_d;
   logic             bout_q, bout_d;
   logic             v_q, v_d;
`ifdef SERIAL_SUB_ADD_MODE_EN
   logic             mode_q, mode_d;
`endif

   logic a_bit, b_bit, sum_bit, bw_next, ovf_bit;
   logic accept, last_bit;

   // A new operation can only be taken when no operation is in flight.
   assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
   assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

   // Single-bit cell; on the last bit a/b are the operand sign bits, so the
   // overflow flag can be formed from the cell's own inputs and output.
   always_comb begin
      a_bit   = a_sh_q[0];
      b_bit   = b_sh_q[0];
      sum_bit = a_bit ^ b_bit ^ bw_q;
      bw_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bw_q);
      ovf_bit = (a_bit ^ b_bit) & (sum_bit ^ a_bit);
`ifdef SERIAL_SUB_ADD_MODE_EN
      if (mode_q) begin
         bw_next = (a_bit & b_bit) | ((a_bit ^ b_bit) & bw_q);
         ovf_bit = ~(a_bit ^ b_bit) & (sum_bit ^ a_bit);
      end
`endif
   end

   // Next-state logic: DONE behaves like IDLE for a waiting start.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT:   if (last_bit) state_d = DONE;
         DONE:    state_d = start ? SHIFT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values: capture on accept, shift one bit per SHIFT cycle.
   always_comb begin
      a_sh_d = a_sh_q;
      b_sh_d = b_sh_q;
      res_d  = res_q;
      cnt_d  = cnt_q;
      bw_d   = bw_q;
      d_d    = d_q;
      bout_d = bout_q;
      v_d    = v_q;
`ifdef SERIAL_SUB_ADD_MODE_EN
      mode_d = mode_q;
`endif
      if (accept) begin
         a_sh_d = A;
         b_sh_d = B;
         bw_d   = Bin;
         cnt_d  = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
         mode_d = mode;
`endif
      end else if (state_q == SHIFT) begin
         a_sh_d = a_sh_q >> 1;
         b_sh_d = b_sh_q >> 1;
         res_d  = {sum_bit, res_q[WIDTH-1:1]};
         bw_d   = bw_next;
         cnt_d  = cnt_q + CNT_W'(1);
         if (last_bit) begin
            d_d    = {sum_bit, res_q[WIDTH-1:1]};
            bout_d = bw_next;
            v_d    = ovf_bit;
         end
      end
   end

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Datapath and held-result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh_q <= '0;
         b_sh_q <= '0;
         res_q  <= '0;
         cnt_q  <= '0;
         bw_q   <= 1'b0;
         d_q    <= '0;
         bout_q <= 1'b0;
         v_q    <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
         mode_q <= 1'b0;
`endif
      end else begin
         a_sh_q <= a_sh_d;
         b_sh_q <= b_sh_d;
         res_q  <= res_d;
         cnt_q  <= cnt_d;
         bw_q   <= bw_d;
         d_q    <= d_d;
         bout_q <= bout_d;
         v_q    <= v_d;
`ifdef SERIAL_SUB_ADD_MODE_EN
         mode_q <= mode_d;
`endif
      end
   end

   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);
   assign D    = d_q;
   assign Bout = bout_q;
   assign V    = v_q;

endmodule
